// File: rtl/swipe_scheduler.sv
// Magstripe swipe sequencer: arbitrates the coil between track 2 and track 3 sources,
// framing each track with sync/trailing zeros and F2F-encoding the cells onto out/out_n.
module swipe_scheduler #(
  parameter int TICK_DIV    = 30000,
  parameter int LEAD_ZEROS  = 40,
  parameter int TRAIL_ZEROS = 5,
  parameter int GAP_TICKS   = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] track_mask,
  input  logic       abort,
  input  logic [1:0] src_valid,
  input  logic [1:0] src_bit,
  input  logic [1:0] src_last,
  output logic [1:0] src_ready,
  output logic       out,
  output logic       out_n,
  output logic       en,
  output logic       busy,
  output logic [1:0] active_track,
  output logic       done,
  output logic       underrun
);

  localparam int ZMAX = (LEAD_ZEROS > TRAIL_ZEROS) ? LEAD_ZEROS : TRAIL_ZEROS;
  localparam int CW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int ZW   = $clog2(ZMAX + 1);
  localparam int GW   = $clog2(GAP_TICKS + 1);

  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [ZW-1:0] LEAD_LAST  = ZW'(LEAD_ZEROS - 1);
  localparam logic [ZW-1:0] TRAIL_LAST = ZW'(TRAIL_ZEROS - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_DATA  = 3'd2,
    S_TRAIL = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic [ZW-1:0]   cell_cnt_q, cell_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [1:0]      mask_q, mask_d;
  logic            trk_q, trk_d;
  logic            cell_bit_q, cell_bit_d;
  logic            last_q, last_d;
  logic            out_q, out_d;
  logic            done_q, done_d;
  logic            underrun_q, underrun_d;
  logic            tick;
  logic            on_coil;

  assign tick    = (state_q != S_IDLE) && (cnt_q == TICK_LAST);
  assign on_coil = (state_q == S_LEAD) || (state_q == S_DATA) || (state_q == S_TRAIL);

  // Next-state, tick/cell counters, F2F encoder and source handshake
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    cell_cnt_d = cell_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    mask_d     = mask_q;
    trk_d      = trk_q;
    cell_bit_d = cell_bit_q;
    last_d     = last_q;
    out_d      = out_q;
    done_d     = 1'b0;
    underrun_d = underrun_q;
    src_ready  = 2'b00;

    if (state_q == S_IDLE) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort && (track_mask != 2'b00)) begin
          mask_d     = track_mask;
          trk_d      = ~track_mask[0];
          underrun_d = 1'b0;
          cell_cnt_d = '0;
          out_d      = 1'b0;
          state_d    = S_LEAD;
        end else begin
          out_d = 1'b0;
        end
      end

      S_LEAD: begin
        if (tick && !phase_q) begin
          out_d = ~out_q;
        end else if (tick && (cell_cnt_q == LEAD_LAST)) begin
          cell_cnt_d = '0;
          state_d    = S_DATA;
        end else if (tick) begin
          cell_cnt_d = cell_cnt_q + 1'b1;
        end else begin
          out_d = out_q;
        end
      end

      S_DATA: begin
        // Bit is fetched at the cell boundary; a missing bit becomes a 0 cell
        if (tick && !phase_q) begin
          out_d = ~out_q;
          if (src_valid[trk_q]) begin
            src_ready[trk_q] = 1'b1;
            cell_bit_d       = src_bit[trk_q];
            last_d           = src_last[trk_q];
          end else begin
            cell_bit_d = 1'b0;
            last_d     = 1'b0;
            underrun_d = 1'b1;
          end
        end else if (tick) begin
          out_d = out_q ^ cell_bit_q;
          if (last_q) begin
            cell_cnt_d = '0;
            state_d    = S_TRAIL;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          out_d = out_q;
        end
      end

      S_TRAIL: begin
        if (tick && !phase_q) begin
          out_d = ~out_q;
        end else if (tick && (cell_cnt_q == TRAIL_LAST)) begin
          out_d = 1'b0;
          if (!trk_q && mask_q[1]) begin
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (tick) begin
          cell_cnt_d = cell_cnt_q + 1'b1;
        end else begin
          out_d = out_q;
        end
      end

      S_GAP: begin
        out_d = 1'b0;
        if (tick && (gap_cnt_q == GAP_LAST)) begin
          trk_d      = 1'b1;
          cell_cnt_d = '0;
          state_d    = S_LEAD;
        end else if (tick) begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q;
        end
      end

      default: begin
        out_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      phase_d   = 1'b0;
      out_d     = 1'b0;
      done_d    = 1'b0;
      src_ready = 2'b00;
    end else begin
      src_ready = src_ready & {2{on_coil}};
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      cell_cnt_q <= '0;
      gap_cnt_q  <= '0;
      mask_q     <= 2'b00;
      trk_q      <= 1'b0;
      cell_bit_q <= 1'b0;
      last_q     <= 1'b0;
      out_q      <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      cell_cnt_q <= cell_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      mask_q     <= mask_d;
      trk_q      <= trk_d;
      cell_bit_q <= cell_bit_d;
      last_q     <= last_d;
      out_q      <= out_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign out          = out_q;
  assign out_n        = ~out_q;
  assign en           = on_coil;
  assign busy         = (state_q != S_IDLE);
  assign active_track = on_coil ? (trk_q ? 2'b10 : 2'b01) : 2'b00;
  assign done         = done_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_swipe_scheduler.sv
// Directed bench for swipe_scheduler: scripted bit sources plus a negedge monitor
// that counts coil activity; expected counts are worked out by hand for the small parameters.
module tb_swipe_scheduler;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [1:0] track_mask;
  logic [1:0] src_valid = 2'b00, src_bit = 2'b00, src_last = 2'b00;
  logic [1:0] src_ready, active_track;
  logic       out, out_n, en, busy, done, underrun;

  swipe_scheduler #(
    .TICK_DIV(4), .LEAD_ZEROS(4), .TRAIL_ZEROS(2), .GAP_TICKS(6)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .track_mask(track_mask), .abort(abort),
    .src_valid(src_valid), .src_bit(src_bit), .src_last(src_last), .src_ready(src_ready),
    .out(out), .out_n(out_n), .en(en), .busy(busy), .active_track(active_track),
    .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Source scripts: bit i of sbits is the i-th bit sent; sinv holds valid low for that many cycles
  logic [15:0] sbits [2];
  int          slen  [2];
  int          sidx  [2];
  int          sinv  [2];
  logic [1:0]  ready_seen = 2'b00;

  int   en_cyc, tgl, rdy0, rdy1, done_cnt, gap_cyc, gap_bad, act2_cyc, act3_cyc, onbad;
  logic prev_out = 1'b0;

  task automatic set_src(input int t, input logic [15:0] bits, input int len, input int inv);
    sbits[t] = bits;
    slen[t]  = len;
    sidx[t]  = 0;
    sinv[t]  = inv;
  endtask

  task automatic clr_mon();
    en_cyc = 0; tgl = 0; rdy0 = 0; rdy1 = 0; done_cnt = 0;
    gap_cyc = 0; gap_bad = 0; act2_cyc = 0; act3_cyc = 0;
  endtask

  // Monitor: samples at the falling edge, mid-cycle
  initial begin
    onbad = 0;
    clr_mon();
    forever begin
      @(negedge clk);
      if (out_n !== ~out) onbad++;
      if (en) begin
        en_cyc++;
        if (out !== prev_out) tgl++;
      end
      if (busy && !en) begin
        gap_cyc++;
        if (out || (active_track != 2'b00)) gap_bad++;
      end
      if (en && active_track == 2'b01) act2_cyc++;
      if (en && active_track == 2'b10) act3_cyc++;
      if (src_ready[0]) rdy0++;
      if (src_ready[1]) rdy1++;
      if (done) done_cnt++;
      prev_out   = out;
      ready_seen = src_ready;
    end
  end

  // Source driver: advances just after the edge that consumed a bit
  initial begin
    for (int t = 0; t < 2; t++) set_src(t, 16'h0000, 0, 0);
    forever begin
      @(posedge clk);
      #1;
      for (int t = 0; t < 2; t++) begin
        if (ready_seen[t]) sidx[t]++;
        if (sinv[t] > 0) begin
          sinv[t]--;
          src_valid[t] = 1'b0;
        end else begin
          src_valid[t] = (sidx[t] < slen[t]);
        end
        src_bit[t]  = sbits[t][sidx[t] % 16];
        src_last[t] = (sidx[t] == slen[t] - 1);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 600) begin
      cyc(1);
      k++;
    end
    check({tag, "_no_timeout"}, int'(k < 600), 1);
    cyc(1);
  endtask

  task automatic run_swipe(input logic [1:0] m, input string tag);
    clr_mon();
    start = 1'b1;
    track_mask = m;
    cyc(1);
    start = 1'b0;
    track_mask = 2'b00;
    check({tag, "_busy"}, int'(busy), 1);
    wait_idle(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out"}, int'(out), 0);
    check({tag, "_out_n"}, int'(out_n), 1);
    check({tag, "_en"}, int'(en), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_active"}, int'(active_track), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_src_ready"}, int'(src_ready), 0);
    check({tag, "_underrun"}, int'(underrun), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; track_mask = 2'b00;
    cyc(3);
    check_reset_vals("reset");
    rst = 1'b0;
    cyc(1);

    // 1: track 2 only, bits 1,0,1
    set_src(0, 16'b101, 3, 0);
    set_src(1, 16'hFFFF, 16, 0);
    run_swipe(2'b01, "t1");
    check("t1_en_cycles", en_cyc, 72);
    check("t1_toggles", tgl, 11);
    check("t1_ready0", rdy0, 3);
    check("t1_ready1", rdy1, 0);
    check("t1_done", done_cnt, 1);
    check("t1_underrun", int'(underrun), 0);
    check("t1_act2_cycles", act2_cyc, 72);
    check("t1_out_idle", int'(out), 0);

    // 2: both tracks, bits 0,1 each, with gap between
    set_src(0, 16'b10, 2, 0);
    set_src(1, 16'b10, 2, 0);
    run_swipe(2'b11, "t2");
    check("t2_en_cycles", en_cyc, 128);
    check("t2_toggles", tgl, 18);
    check("t2_ready0", rdy0, 2);
    check("t2_ready1", rdy1, 2);
    check("t2_done", done_cnt, 1);
    check("t2_gap_cycles", gap_cyc, 24);
    check("t2_gap_bad", gap_bad, 0);
    check("t2_act2_cycles", act2_cyc, 64);
    check("t2_act3_cycles", act3_cyc, 64);

    // 3: first data cell starved, then single bit 1 (last)
    set_src(0, 16'b1, 1, 40);
    set_src(1, 16'h0000, 0, 0);
    run_swipe(2'b01, "t3");
    check("t3_underrun", int'(underrun), 1);
    check("t3_en_cycles", en_cyc, 64);
    check("t3_toggles", tgl, 9);
    check("t3_ready0", rdy0, 1);
    check("t3_done", done_cnt, 1);

    // 4: abort in the middle of DATA
    set_src(0, 16'hFFFF, 16, 0);
    clr_mon();
    start = 1'b1; track_mask = 2'b01;
    cyc(1);
    start = 1'b0; track_mask = 2'b00;
    check("t4_underrun_cleared", int'(underrun), 0);
    cyc(44);
    check("t4_ready_before_abort", rdy0, 2);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    check("t4_busy", int'(busy), 0);
    check("t4_en", int'(en), 0);
    check("t4_out", int'(out), 0);
    check("t4_active", int'(active_track), 0);
    cyc(30);
    check("t4_ready_after_abort", rdy0, 2);
    check("t4_no_done", done_cnt, 0);
    set_src(0, 16'b1, 1, 0);
    run_swipe(2'b01, "t4b");
    check("t4b_en_cycles", en_cyc, 56);
    check("t4b_done", done_cnt, 1);
    check("t4b_ready0", rdy0, 1);

    // 5: reset mid-LEAD, then ignored starts
    set_src(0, 16'hFFFF, 16, 0);
    set_src(1, 16'hFFFF, 16, 0);
    start = 1'b1; track_mask = 2'b01;
    cyc(1);
    start = 1'b0; track_mask = 2'b00;
    cyc(8);
    rst = 1'b1;
    cyc(1);
    check_reset_vals("t5_rst");
    rst = 1'b0;
    cyc(1);
    start = 1'b1; track_mask = 2'b00;
    cyc(1);
    start = 1'b0;
    check("t5_mask0_busy", int'(busy), 0);
    cyc(2);
    check("t5_mask0_en", int'(en), 0);
    set_src(0, 16'b1, 1, 0);
    clr_mon();
    start = 1'b1; track_mask = 2'b01;
    cyc(1);
    start = 1'b0; track_mask = 2'b00;
    cyc(5);
    start = 1'b1; track_mask = 2'b10;
    cyc(1);
    start = 1'b0; track_mask = 2'b00;
    check("t5_busy_kept", int'(busy), 1);
    check("t5_active_kept", int'(active_track), 1);
    wait_idle("t5");
    check("t5_en_cycles", en_cyc, 56);
    check("t5_ready1", rdy1, 0);
    check("t5_act3_cycles", act3_cyc, 0);
    check("t5_done", done_cnt, 1);

    // 6: start and abort together in IDLE
    clr_mon();
    start = 1'b1; abort = 1'b1; track_mask = 2'b01;
    cyc(1);
    start = 1'b0; abort = 1'b0; track_mask = 2'b00;
    check("t6_busy", int'(busy), 0);
    check("t6_en", int'(en), 0);
    cyc(5);
    check("t6_busy_later", int'(busy), 0);
    check("t6_en_cycles", en_cyc, 0);

    check("out_n_complement", onbad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/swipe_scheduler.md
Name: swipe_scheduler

Overview:
- Sequences one magstripe swipe onto the single coil/H-bridge driver.
- Arbitrates the coil between two track bit sources, track 2 and track 3, served in fixed order.
- Per track it inserts leading sync zeros, the streamed data bits and trailing zeros, then an inter-track gap with the driver disabled.
- Performs F2F (Aiken biphase) encoding onto out/out_n and controls en for the H-bridge.

Parameters:
TICK_DIV, 30000, clocks per half-bit tick (>=2)
LEAD_ZEROS, 40, sync zero bit cells before each track's data (>=1)
TRAIL_ZEROS, 5, zero bit cells after each track's data (>=1)
GAP_TICKS, 90, half-bit ticks with en low between track 2 and track 3 (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle swipe request; sampled only in IDLE
track_mask  in  2  [0]=send track 2, [1]=send track 3; sampled with start
abort  in  1  terminate swipe immediately
src_valid  in  2  per-track: src_bit/src_last valid
src_bit  in  2  per-track data bit, LSB-first order owned by source
src_last  in  2  per-track: current bit is final data bit
src_ready  out  2  per-track one-cycle consume strobe
out  out  1  coil drive
out_n  out  1  always ~out
en  out  1  H-bridge enable
busy  out  1  high whenever state != IDLE
active_track  out  2  one-hot track currently granted; 0 in IDLE/GAP
done  out  1  one-cycle pulse on normal completion
underrun  out  1  sticky: source not valid when a data bit was needed

Behaviour:
- Reset (and reset mid-swipe): state=IDLE; out=0, out_n=1, en=0, busy=0, active_track=0, done=0, src_ready=0, underrun=0; counters cleared.
- States: IDLE, LEAD, DATA, TRAIL, GAP.
- Tick generator: counter runs only when not IDLE; cleared on leaving IDLE and on every state entry. tick pulses when count==TICK_DIV-1; the counter then wraps to 0. A bit cell is 2 ticks: phase0 then phase1.
- F2F encoding:
  - phase0 tick: out toggles (cell boundary).
  - phase1 tick: out toggles again only if the cell bit is 1.
  - out changes the cycle after the tick.
- IDLE: start=1 with track_mask!=0 and abort=0 latches the mask. Next cycle: LEAD for the lowest selected track, en=1, active_track set, underrun cleared. start with mask=0 is ignored. start while busy is ignored.
- LEAD: sends LEAD_ZEROS zero cells, then enters DATA.
- DATA: at each phase0 tick for the granted track t:
  - src_valid[t]=1: consume src_bit[t] with a src_ready[t] pulse in the same cycle.
  - src_valid[t]=0: send 0 and set underrun. No src_ready pulse, and src_last is not honoured.
  - After the cell whose consumed bit had src_last=1: enter TRAIL.
- TRAIL: sends TRAIL_ZEROS zero cells. Then:
  - other track still pending: GAP, with en=0, out=0, active_track=0.
  - no track pending: IDLE, with en=0, out=0, done=1 for one cycle.
- GAP: GAP_TICKS ticks, then LEAD for track 3 with en=1 and active_track=2'b10.
- abort=1 in any non-IDLE state: next cycle IDLE, en=0, out=0, no done, no further src_ready. abort wins over simultaneous start. abort in IDLE has no effect.
- src_ready is never asserted for the non-granted track or outside DATA.
- Counters are sized to hold parameter maxima with no wrap. Track bit length is unbounded and governed by src_last only.

Test Plan:
Common parameters: TICK_DIV=4, LEAD_ZEROS=4, TRAIL_ZEROS=2, GAP_TICKS=6.
1. start, mask=01; track-2 source holds bits 1,0,1 (last on 3rd) valid -> en high for 72 cycles; 11 out toggles (4 lead + 5 data + 2 trail); 3 src_ready[0] pulses; done pulse once; underrun=0; src_ready[1] never asserted.
2. mask=11, both sources give 2 bits (0,1) -> track 2 sequence, then en low with out=0 and active_track=0 for 24 cycles, then track 3 sequence; one done at end; 4 total src_ready pulses split 2/2.
3. mask=01, src_valid[0] low during the first data cell, valid afterwards with a single bit 1 (last) -> underrun=1; first data cell encodes 0 (1 toggle); trailing sequence completes; underrun cleared on next accepted start.
4. abort mid-DATA -> next cycle IDLE, en=0, out=0, busy=0; no done; no src_ready afterwards; new start accepted normally.
5. rst asserted mid-LEAD -> all outputs return to reset values the next cycle. start with mask=00, and start while busy -> both ignored (busy/state unchanged).
6. start and abort in the same IDLE cycle -> remains IDLE, en stays 0.
